// File: rtl/fano_bit_packer.sv
// ---------------------------------------------------------------------------
// fano_bit_packer
//
// Packs the decoded bit stream of one Fano decoder channel into DATA_WIDTH-bit
// words. Words are buffered in a small FIFO and emitted on an AXI-Stream
// master toward the DMA / packet framer. One instance is used per channel.
//
// A word is closed when:
//   - its last slot is filled (tuser = DATA_WIDTH, tlast = 0), or
//   - a flush event occurs with at least one bit held (tuser = bit count,
//     tlast = 1).
// A flush event is an i_flush pulse or a falling edge of i_is_sync.
//
// Ports
//   clk             clock, single domain
//   reset_n         asynchronous active-low reset
//   i_vld           decoded bit strobe
//   i_dec_sym       decoded bit
//   i_is_sync       decoder in sync; bits are accepted only while 1
//   i_flush         one-cycle pulse: close the partial word
//   m_axis_tdata    packed word
//   m_axis_tuser    number of valid bits in the beat (1..DATA_WIDTH)
//   m_axis_tlast    beat closed by flush or sync loss
//   m_axis_tvalid   beat valid (FIFO not empty)
//   m_axis_tready   sink ready
//   o_fifo_level    words currently stored (0..FIFO_DEPTH)
//   o_overflow_cnt  words dropped because the FIFO was full; saturates
//
// Handshake: a beat transfers on every rising clk edge where tvalid && tready
// are both 1. tvalid never depends on tready, and tdata/tuser/tlast hold
// steady while tvalid && !tready. When tvalid is 0 the payload outputs are 0.
// ---------------------------------------------------------------------------
module fano_bit_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_vld,
  input  logic                            i_dec_sym,
  input  logic                            i_is_sync,
  input  logic                            i_flush,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [$clog2(DATA_WIDTH):0]     m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
  output logic [15:0]                     o_overflow_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Packer state
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] acc;        // partial word, unused bits held at 0
  logic [CNT_W-1:0]      bit_cnt;    // slot of the next accepted bit
  logic                  sync_q;     // i_is_sync from the previous cycle

  logic                  accept;
  logic                  flush_evt;
  logic [CNT_W-1:0]      slot_pos;   // bit position in acc for this slot
  logic [DATA_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]      cnt_after;  // bits held once this cycle's bit is in
  logic                  word_full;
  logic                  close_word;

  assign accept    = i_vld & i_is_sync;
  // Sync loss behaves like a flush so a partial word is not left stranded.
  assign flush_evt = i_flush | (sync_q & ~i_is_sync);

  assign slot_pos  = MSB_FIRST ? (LAST_SLOT - bit_cnt) : bit_cnt;
  assign cnt_after = bit_cnt + {{(CNT_W-1){1'b0}}, accept};
  assign word_full = accept & (bit_cnt == LAST_SLOT);
  // A flush counts the bit arriving in the same cycle, so the word closes
  // with that bit included.
  assign close_word = word_full | (flush_evt & (cnt_after != '0));

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (accept && (slot_pos == CNT_W'(i))) begin
        acc_next[i] = i_dec_sym;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      bit_cnt <= '0;
      sync_q  <= 1'b0;
    end else begin
      sync_q <= i_is_sync;
      // The packer restarts after every close, even if the FIFO drops it.
      if (close_word) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else if (accept) begin
        acc     <= acc_next;
        bit_cnt <= cnt_after;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CNT_W-1:0]      mem_user [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;

  assign fifo_full  = (level == LEVEL_FULL);
  assign fifo_empty = (level == '0);
  assign pop        = ~fifo_empty & m_axis_tready;
  // A full FIFO can still take a word when a beat leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign push       = close_word & (~fifo_full | pop);
  assign drop       = close_word & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= acc_next;
      mem_user[wr_ptr] <= cnt_after;
      mem_last[wr_ptr] <= flush_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_overflow_cnt <= '0;
    end else if (drop && (o_overflow_cnt != 16'hFFFF)) begin
      o_overflow_cnt <= o_overflow_cnt + 16'd1;
    end
  end

  // Payload outputs are forced to 0 while empty so reset shows all zeros.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0   : mem_data[rd_ptr];
  assign m_axis_tuser  = fifo_empty ? '0   : mem_user[rd_ptr];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : mem_last[rd_ptr];
  assign o_fifo_level  = level;

endmodule
